// File: rtl/sram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : sram_port_arbiter
// Brief   : Round-robin arbiter that shares one single-port SRAM macro between
//           two burst requesters and sequences the macro pins cycle by cycle.
// Revision: 1.0 - initial release
// ============================================================================
module sram_port_arbiter #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m0_req,
    input  logic                  m0_write,
    input  logic [ADDR_W-1:0]     m0_addr,
    input  logic [LEN_W-1:0]      m0_len,
    input  logic                  m0_wvalid,
    input  logic [DATA_W-1:0]     m0_wdata,
    input  logic [DATA_W/8-1:0]   m0_wstrb,
    output logic                  m0_gnt,
    output logic                  m0_wready,
    output logic                  m0_rvalid,
    output logic [DATA_W-1:0]     m0_rdata,
    output logic                  m0_done,
    input  logic                  m1_req,
    input  logic                  m1_write,
    input  logic [ADDR_W-1:0]     m1_addr,
    input  logic [LEN_W-1:0]      m1_len,
    input  logic                  m1_wvalid,
    input  logic [DATA_W-1:0]     m1_wdata,
    input  logic [DATA_W/8-1:0]   m1_wstrb,
    output logic                  m1_gnt,
    output logic                  m1_wready,
    output logic                  m1_rvalid,
    output logic [DATA_W-1:0]     m1_rdata,
    output logic                  m1_done,
    output logic                  sram_cs,
    output logic                  sram_oe,
    output logic [DATA_W/8-1:0]   sram_web,
    output logic [ADDR_W-1:0]     sram_a,
    output logic [DATA_W-1:0]     sram_di,
    input  logic [DATA_W-1:0]     sram_do
);

    localparam int c_NB = DATA_W / 8;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_READ   = 2'd1,
        S_RDRAIN = 2'd2,
        S_WRITE  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_owner;
    logic                r_last_gnt;
    logic                r_rd_pend;
    logic [ADDR_W-1:0]   r_base;
    logic [LEN_W-1:0]    r_len;
    logic [LEN_W-1:0]    r_cnt;

    logic                w_gnt_vld;
    logic                w_gnt_id;
    logic                w_sel_write;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [LEN_W-1:0]    w_sel_len;
    logic                w_own_wvalid;
    logic [DATA_W-1:0]   w_own_wdata;
    logic [c_NB-1:0]     w_own_wstrb;
    logic [ADDR_W-1:0]   w_addr;
    logic                w_last_beat;
    logic                w_beat;
    logic                w_done;
    logic                w_wready;

    // On a tie the requester that was not served last wins.
    assign w_gnt_id    = (m0_req && m1_req) ? ~r_last_gnt : ~m0_req;
    assign w_gnt_vld   = (r_state == S_IDLE) && (m0_req || m1_req);
    assign w_sel_write = w_gnt_id ? m1_write : m0_write;
    assign w_sel_addr  = w_gnt_id ? m1_addr  : m0_addr;
    assign w_sel_len   = w_gnt_id ? m1_len   : m0_len;

    assign w_own_wvalid = r_owner ? m1_wvalid : m0_wvalid;
    assign w_own_wdata  = r_owner ? m1_wdata  : m0_wdata;
    assign w_own_wstrb  = r_owner ? m1_wstrb  : m0_wstrb;
    assign w_addr       = r_base + ADDR_W'(r_cnt);
    assign w_last_beat  = (r_cnt == r_len);

    always_comb begin
        w_state_nxt = r_state;
        sram_cs     = 1'b0;
        sram_oe     = 1'b0;
        sram_web    = '1;
        sram_a      = '0;
        sram_di     = '0;
        w_beat      = 1'b0;
        w_done      = 1'b0;
        w_wready    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_gnt_vld) begin
                    w_state_nxt = w_sel_write ? S_WRITE : S_READ;
                end
            end
            S_READ: begin
                sram_cs = 1'b1;
                sram_oe = 1'b1;
                sram_a  = w_addr;
                if (w_last_beat) begin
                    w_state_nxt = S_RDRAIN;
                end
            end
            S_RDRAIN: begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            S_WRITE: begin
                sram_cs  = 1'b1;
                w_wready = 1'b1;
                sram_a   = w_addr;
                sram_di  = w_own_wdata;
                if (w_own_wvalid) begin
                    sram_web = ~w_own_wstrb;
                    w_beat   = 1'b1;
                    if (w_last_beat) begin
                        w_done      = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_last_gnt <= 1'b1;
            r_cnt      <= '0;
            r_rd_pend  <= 1'b0;
            r_owner    <= 1'b0;
            r_base     <= '0;
            r_len      <= '0;
        end else begin
            r_state   <= w_state_nxt;
            // Macro data appears one cycle after its address.
            r_rd_pend <= (r_state == S_READ);
            case (r_state)
                S_IDLE: begin
                    if (w_gnt_vld) begin
                        r_owner <= w_gnt_id;
                        r_base  <= w_sel_addr;
                        r_len   <= w_sel_len;
                        r_cnt   <= '0;
                    end
                end
                S_READ:   r_cnt <= r_cnt + LEN_W'(1);
                S_RDRAIN: r_last_gnt <= r_owner;
                S_WRITE: begin
                    if (w_beat) begin
                        r_cnt <= r_cnt + LEN_W'(1);
                        if (w_last_beat) begin
                            r_last_gnt <= r_owner;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign m0_gnt    = w_gnt_vld && !w_gnt_id;
    assign m1_gnt    = w_gnt_vld &&  w_gnt_id;
    assign m0_wready = w_wready && !r_owner;
    assign m1_wready = w_wready &&  r_owner;
    assign m0_done   = w_done && !r_owner;
    assign m1_done   = w_done &&  r_owner;
    assign m0_rvalid = r_rd_pend && !r_owner;
    assign m1_rvalid = r_rd_pend &&  r_owner;
    assign m0_rdata  = m0_rvalid ? sram_do : '0;
    assign m1_rdata  = m1_rvalid ? sram_do : '0;

endmodule
`default_nettype wire

// File: tb/tb_sram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_sram_port_arbiter
// Brief   : Self-checking bench: directed vector table, multi-cycle corner
//           sequences and randomized two-master traffic against a memory model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_sram_port_arbiter;
    localparam int AW = 14;
    localparam int DW = 32;
    localparam int LW = 4;
    localparam int NB = 4;

    typedef struct packed {
        logic          req;
        logic          wr;
        logic [AW-1:0] addr;
        logic [LW-1:0] len;
        logic          wv;
        logic [NB-1:0] strb;
        logic [DW-1:0] wd;
        logic          gnt;
        logic          wrdy;
        logic          rv;
        logic          done;
        logic          cs;
        logic          oe;
        logic [NB-1:0] web;
        logic [AW-1:0] a;
        logic [DW-1:0] rd;
        logic [DW-1:0] di;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          m_req[2], m_write[2], m_wvalid[2];
    logic [AW-1:0] m_addr[2];
    logic [LW-1:0] m_len[2];
    logic [DW-1:0] m_wdata[2];
    logic [NB-1:0] m_wstrb[2];
    logic          m_gnt[2], m_wready[2], m_rvalid[2], m_done[2];
    logic [DW-1:0] m_rdata[2];
    logic          sram_cs, sram_oe;
    logic [NB-1:0] sram_web;
    logic [AW-1:0] sram_a;
    logic [DW-1:0] sram_di, sram_do;

    bit   [DW-1:0] mem[1<<AW];
    bit   [DW-1:0] ref_mem[1<<AW];
    logic          pl_en;
    logic [AW-1:0] pl_a;
    logic [DW-1:0] pl_d;

    int checks = 0;
    int errors = 0;

    sram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m_req[0]), .m0_write(m_write[0]), .m0_addr(m_addr[0]), .m0_len(m_len[0]),
        .m0_wvalid(m_wvalid[0]), .m0_wdata(m_wdata[0]), .m0_wstrb(m_wstrb[0]),
        .m0_gnt(m_gnt[0]), .m0_wready(m_wready[0]), .m0_rvalid(m_rvalid[0]),
        .m0_rdata(m_rdata[0]), .m0_done(m_done[0]),
        .m1_req(m_req[1]), .m1_write(m_write[1]), .m1_addr(m_addr[1]), .m1_len(m_len[1]),
        .m1_wvalid(m_wvalid[1]), .m1_wdata(m_wdata[1]), .m1_wstrb(m_wstrb[1]),
        .m1_gnt(m_gnt[1]), .m1_wready(m_wready[1]), .m1_rvalid(m_rvalid[1]),
        .m1_rdata(m_rdata[1]), .m1_done(m_done[1]),
        .sram_cs(sram_cs), .sram_oe(sram_oe), .sram_web(sram_web), .sram_a(sram_a),
        .sram_di(sram_di), .sram_do(sram_do)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                            input logic [NB-1:0] strb);
        logic [DW-1:0] r;
        r = old;
        for (int b = 0; b < NB; b++) if (strb[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    // Macro model: registered read data, byte-masked writes, plus a backdoor preload.
    always @(posedge clk) begin
        if (pl_en) begin
            mem[pl_a] <= pl_d;
        end else if (sram_cs) begin
            if (sram_oe) sram_do <= mem[sram_a];
            mem[sram_a] <= merge(mem[sram_a], sram_di, ~sram_web);
        end
    end

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pl_en = 1'b1; pl_a = a; pl_d = d; ref_mem[a] = d;
        cyc();
        pl_en = 1'b0;
    endtask

    // Arbitration / ownership monitor derived from the grant rules.
    int   mon_busy = 0;
    int   mon_owner = 0;
    logic mon_last = 1'b1;
    initial begin
        logic [1:0] eg, stray;
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_busy = 0;
                mon_last = 1'b1;
            end else begin
                eg = 2'b00;
                if (mon_busy == 0 && (m_req[0] || m_req[1])) begin
                    if (m_req[0] && m_req[1]) eg = mon_last ? 2'b01 : 2'b10;
                    else                      eg = m_req[0] ? 2'b01 : 2'b10;
                end
                chk("arb_gnt", 128'({m_gnt[1], m_gnt[0]}), 128'(eg));
                for (int i = 0; i < 2; i++)
                    stray[i] = (m_rvalid[i] | m_wready[i] | m_done[i]) && !(mon_busy != 0 && mon_owner == i);
                chk("non_owner_out", 128'(stray), 128'(0));
                if (mon_busy != 0 && m_done[mon_owner]) begin
                    mon_busy = 0;
                    mon_last = mon_owner[0];
                end
                if (m_gnt[0])      begin mon_busy = 1; mon_owner = 0; end
                else if (m_gnt[1]) begin mon_busy = 1; mon_owner = 1; end
            end
        end
    end

    task automatic master_run(input int id, input int ntx);
        logic [AW-1:0] addr;
        logic [LW-1:0] len;
        logic          wr;
        int            beat, n, acc;
        for (int t = 0; t < ntx; t++) begin
            repeat ($urandom_range(0, 3)) cyc();
            wr   = 1'($urandom_range(0, 1));
            addr = ($urandom_range(0, 3) == 0) ? AW'(14'h3FFC + 14'($urandom_range(0, 3))) : AW'($urandom);
            len  = LW'($urandom_range(0, 3));
            m_req[id] = 1'b1; m_write[id] = wr; m_addr[id] = addr; m_len[id] = len;
            n = 0;
            while (n < 200) begin
                @(negedge clk);
                if (m_gnt[id]) break;
                cyc();
                n++;
            end
            chk("rnd_gnt_timeout", 128'(n < 200), 128'(1));
            if (n < 200) cyc();
            m_req[id] = 1'b0;
            if (n >= 200) continue;
            beat = 0;
            n = 0;
            if (wr) begin
                while (beat <= int'(len) && n < 100) begin
                    m_wvalid[id] = ($urandom_range(0, 3) != 0);
                    m_wdata[id]  = $urandom;
                    m_wstrb[id]  = NB'($urandom_range(0, 15));
                    @(negedge clk);
                    chk("rnd_wready", 128'(m_wready[id]), 128'(1));
                    acc = (m_wvalid[id] && m_wready[id]) ? 1 : 0;
                    chk("rnd_wdone", 128'(m_done[id]), 128'(acc == 1 && beat == int'(len)));
                    if (acc == 1) begin
                        ref_mem[addr + AW'(beat)] = merge(ref_mem[addr + AW'(beat)], m_wdata[id], m_wstrb[id]);
                        beat++;
                    end
                    cyc();
                    n++;
                end
                m_wvalid[id] = 1'b0;
            end else begin
                while (beat <= int'(len) && n < int'(len) + 4) begin
                    @(negedge clk);
                    if (m_rvalid[id]) begin
                        chk("rnd_rdata", 128'(m_rdata[id]), 128'(ref_mem[addr + AW'(beat)]));
                        chk("rnd_rdone", 128'(m_done[id]), 128'(beat == int'(len)));
                        beat++;
                    end
                    cyc();
                    n++;
                end
            end
            chk("rnd_beats", 128'(beat), 128'(int'(len) + 1));
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1);
    end

    initial begin
        vec_t          tv[15];
        logic [AW-1:0] wa[4];
        logic [DW-1:0] wdv[4];
        logic [DW-1:0] erd;
        int            order[$];
        int            done_c, g_c, beats;
        logic [3:0]    wvp;

        tv[0]  = '{1'b1,1'b0,14'h010,4'd0,1'b0,4'h0,32'h0,         1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,4'hF,14'h000,32'h0,32'h0};
        tv[1]  = '{1'b0,1'b0,14'h000,4'd0,1'b0,4'h0,32'h0,         1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,4'hF,14'h010,32'h0,32'h0};
        tv[2]  = '{1'b0,1'b0,14'h000,4'd0,1'b0,4'h0,32'h0,         1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,4'hF,14'h000,32'hDEADBEEF,32'h0};
        tv[3]  = '{1'b0,1'b0,14'h000,4'd0,1'b0,4'h0,32'h0,         1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,4'hF,14'h000,32'h0,32'h0};
        tv[4]  = '{1'b1,1'b1,14'h100,4'd2,1'b0,4'h0,32'h0,         1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,4'hF,14'h000,32'h0,32'h0};
        tv[5]  = '{1'b0,1'b0,14'h000,4'd0,1'b1,4'hF,32'hAAAAAAAA,  1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,4'h0,14'h100,32'h0,32'hAAAAAAAA};
        tv[6]  = '{1'b0,1'b0,14'h000,4'd0,1'b0,4'h0,32'h0,         1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,4'hF,14'h101,32'h0,32'h0};
        tv[7]  = '{1'b0,1'b0,14'h000,4'd0,1'b1,4'h3,32'hBBBBBBBB,  1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,4'hC,14'h101,32'h0,32'hBBBBBBBB};
        tv[8]  = '{1'b0,1'b0,14'h000,4'd0,1'b1,4'h8,32'hCCCCCCCC,  1'b0,1'b1,1'b0,1'b1,1'b1,1'b0,4'h7,14'h102,32'h0,32'hCCCCCCCC};
        tv[9]  = '{1'b1,1'b0,14'h100,4'd2,1'b0,4'h0,32'h0,         1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,4'hF,14'h000,32'h0,32'h0};
        tv[10] = '{1'b0,1'b0,14'h000,4'd0,1'b0,4'h0,32'h0,         1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,4'hF,14'h100,32'h0,32'h0};
        tv[11] = '{1'b0,1'b0,14'h000,4'd0,1'b0,4'h0,32'h0,         1'b0,1'b0,1'b1,1'b0,1'b1,1'b1,4'hF,14'h101,32'hAAAAAAAA,32'h0};
        tv[12] = '{1'b0,1'b0,14'h000,4'd0,1'b0,4'h0,32'h0,         1'b0,1'b0,1'b1,1'b0,1'b1,1'b1,4'hF,14'h102,32'h2222BBBB,32'h0};
        tv[13] = '{1'b0,1'b0,14'h000,4'd0,1'b0,4'h0,32'h0,         1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,4'hF,14'h000,32'hCC333333,32'h0};
        tv[14] = '{1'b0,1'b0,14'h000,4'd0,1'b0,4'h0,32'h0,         1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,4'hF,14'h000,32'h0,32'h0};

        rst = 1'b1; pl_en = 1'b0; pl_a = '0; pl_d = '0;
        for (int i = 0; i < 2; i++) begin
            m_req[i] = 1'b0; m_write[i] = 1'b0; m_addr[i] = '0; m_len[i] = '0;
            m_wvalid[i] = 1'b0; m_wdata[i] = '0; m_wstrb[i] = '0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_ctrl", 128'({m_gnt[0], m_gnt[1], m_wready[0], m_wready[1], m_rvalid[0], m_rvalid[1],
                                m_done[0], m_done[1], sram_cs, sram_oe, sram_web, sram_a, sram_di}),
            128'({8'h00, 2'b00, 4'hF, 14'h0, 32'h0}));
        chk("reset_rdata", 128'({m_rdata[0], m_rdata[1]}), 128'(0));
        cyc();
        rst = 1'b0;

        preload(14'h010, 32'hDEADBEEF);
        preload(14'h100, 32'h11111111);
        preload(14'h101, 32'h22222222);
        preload(14'h102, 32'h33333333);

        for (int i = 0; i < 15; i++) begin
            m_req[0] = tv[i].req; m_write[0] = tv[i].wr; m_addr[0] = tv[i].addr; m_len[0] = tv[i].len;
            m_wvalid[0] = tv[i].wv; m_wstrb[0] = tv[i].strb; m_wdata[0] = tv[i].wd;
            @(negedge clk);
            chk($sformatf("vec%0d", i),
                128'({m_gnt[0], m_wready[0], m_rvalid[0], m_done[0], sram_cs, sram_oe, sram_web, sram_a, m_rdata[0], sram_di}),
                128'({tv[i].gnt, tv[i].wrdy, tv[i].rv, tv[i].done, tv[i].cs, tv[i].oe, tv[i].web, tv[i].a, tv[i].rd, tv[i].di}));
            cyc();
        end
        ref_mem[14'h100] = 32'hAAAAAAAA;
        ref_mem[14'h101] = 32'h2222BBBB;
        ref_mem[14'h102] = 32'hCC333333;

        // m1 incrementing read across the top of the address space.
        wa[0] = 14'h3FFE; wa[1] = 14'h3FFF; wa[2] = 14'h0000; wa[3] = 14'h0001;
        for (int k = 0; k < 4; k++) begin
            wdv[k] = 32'h10000000 + DW'(k) * 32'h01010101;
            preload(wa[k], wdv[k]);
        end
        m_req[1] = 1'b1; m_write[1] = 1'b0; m_addr[1] = 14'h3FFE; m_len[1] = 4'd3;
        @(negedge clk);
        chk("wrap_gnt", 128'(m_gnt[1]), 128'(1));
        cyc();
        m_req[1] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            erd = (k >= 1) ? wdv[(k >= 1) ? k - 1 : 0] : 32'h0;
            chk($sformatf("wrap_beat%0d", k),
                128'({sram_cs, sram_oe, sram_a, m_rvalid[1], m_rdata[1], m_done[1]}),
                128'({k < 4, k < 4, (k < 4) ? wa[(k < 4) ? k : 0] : 14'h0, k >= 1, erd, k == 4}));
            cyc();
        end

        // Both masters hold requests right after reset: strict alternation.
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        m_req[0] = 1'b1; m_write[0] = 1'b0; m_addr[0] = 14'h020; m_len[0] = 4'd0;
        m_req[1] = 1'b1; m_write[1] = 1'b0; m_addr[1] = 14'h030; m_len[1] = 4'd0;
        for (int c = 0; c < 11; c++) begin
            @(negedge clk);
            if (m_gnt[0]) order.push_back(0);
            else if (m_gnt[1]) order.push_back(1);
            cyc();
        end
        m_req[0] = 1'b0; m_req[1] = 1'b0;
        chk("arb_count", 128'(order.size()), 128'(4));
        for (int i = 0; i < order.size() && i < 4; i++)
            chk($sformatf("arb_order%0d", i), 128'(order[i]), 128'(i % 2));
        repeat (2) cyc();

        // Reset during the second beat of a long read aborts it silently.
        m_req[0] = 1'b1; m_write[0] = 1'b0; m_addr[0] = 14'h040; m_len[0] = 4'd7;
        @(negedge clk);
        chk("rstb_gnt", 128'(m_gnt[0]), 128'(1));
        cyc();
        m_req[0] = 1'b0;
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("rstb_abort", 128'({sram_cs, sram_oe, sram_web, m_rvalid[0], m_done[0], m_gnt[0]}),
            128'({1'b0, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0}));
        for (int c = 0; c < 3; c++) begin
            cyc();
            @(negedge clk);
            chk("rstb_quiet", 128'({m_rvalid[0], m_done[0], sram_cs}), 128'(0));
        end
        cyc();
        m_req[0] = 1'b1; m_addr[0] = 14'h010; m_len[0] = 4'd0;
        @(negedge clk);
        chk("rstb_regnt", 128'(m_gnt[0]), 128'(1));
        cyc();
        m_req[0] = 1'b0;
        cyc();
        @(negedge clk);
        chk("rstb_reread", 128'({m_rvalid[0], m_done[0], m_rdata[0]}), 128'({1'b1, 1'b1, 32'hDEADBEEF}));
        cyc();

        // m1 waits while m0 writes; granted in the IDLE cycle after m0_done.
        m_req[0] = 1'b1; m_write[0] = 1'b1; m_addr[0] = 14'h200; m_len[0] = 4'd1; m_wvalid[0] = 1'b0;
        @(negedge clk);
        chk("hold_m0_gnt", 128'(m_gnt[0]), 128'(1));
        cyc();
        m_req[0] = 1'b0;
        m_req[1] = 1'b1; m_write[1] = 1'b0; m_addr[1] = 14'h300; m_len[1] = 4'd0;
        wvp = 4'b1010;
        done_c = -1; g_c = -1; beats = 0;
        for (int c = 0; c < 6; c++) begin
            m_wvalid[0] = (c < 4) ? wvp[(c < 4) ? c : 0] : 1'b0;
            m_wstrb[0]  = 4'hF;
            m_wdata[0]  = 32'h5A5A0000 + DW'(c);
            @(negedge clk);
            if (m_wvalid[0] && m_wready[0]) begin
                ref_mem[14'h200 + AW'(beats)] = merge(ref_mem[14'h200 + AW'(beats)], m_wdata[0], 4'hF);
                beats++;
            end
            if (m_done[0]) done_c = c;
            if (m_gnt[1]) g_c = c;
            cyc();
            if (g_c == c) m_req[1] = 1'b0;
        end
        m_wvalid[0] = 1'b0;
        chk("hold_done_cycle", 128'(done_c), 128'(3));
        chk("hold_m1_gnt_cycle", 128'(g_c), 128'(4));
        repeat (2) cyc();

        fork
            master_run(0, 50);
            master_run(1, 50);
        join
        repeat (3) cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
